// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, fill count, sticky errors and optional FWFT read
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   write, data_in        write request and data
//   read                  read request
//   err_clr               clears the sticky overflow/underflow flags
//   data_out              read data (registered, or head word in FWFT mode)
//   full, empty           count == DEPTH, count == 0
//   almost_full/_empty    count >= AF_THRESH, count <= AE_THRESH
//   count                 number of stored words
//   overflow, underflow   sticky: a write / read was dropped
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    assign w_empty      = r_count == '0;
    assign w_full       = r_count == CW'(DEPTH);
    assign w_rd_ok      = read && !w_empty;
    // a read accepted at full frees the slot this write lands in
    assign w_wr_ok      = write && (!w_full || w_rd_ok);
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = r_count >= CW'(AF_THRESH);
    assign almost_empty = r_count <= CW'(AE_THRESH);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
            if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
            if (w_wr_ok && !w_rd_ok) r_count <= r_count + CW'(1);
            else if (w_rd_ok && !w_wr_ok) r_count <= r_count - CW'(1);
            // a new drop event in the clearing cycle keeps the flag set
            r_ovf <= (write && !w_wr_ok) || (r_ovf && !err_clr);
            r_unf <= (read && !w_rd_ok) || (r_unf && !err_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset) r_mem[r_wptr] <= data_in;
    end
    if (FWFT != 0) begin : g_fwft
        assign data_out = w_empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;
        always_ff @(posedge clk) begin
            if (reset) r_dout <= '0;
            else if (w_rd_ok) r_dout <= r_mem[r_rptr];
        end
        assign data_out = r_dout;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    logic       write2 = 1'b0;
    logic       read2 = 1'b0;
    logic [7:0] data_in2 = '0;
    logic [7:0] data_out2;
    logic       full2, empty2, af2, ae2, ovf2, unf2;
    logic [4:0] count2;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .write(write), .data_in(data_in), .read(read),
        .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );
    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .write(write2), .data_in(data_in2), .read(read2),
        .err_clr(1'b0), .data_out(data_out2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count(count2),
        .overflow(ovf2), .underflow(unf2)
    );
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            write = 1'b1;
            data_in = base + 8'(i);
            cyc();
        end
        write = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", data_out); end
        checks++; if (data_out2 !== 8'h00 || empty2 !== 1'b1) begin errors++; $display("FAIL reset_fwft got %h/%b exp 00/1", data_out2, empty2); end
    endtask
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            write = 1'b1;
            data_in = 8'(i);
            cyc();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
            checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_af at %0d got %b exp %b", i, almost_full, i >= 14); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_ae at %0d got %b exp %b", i, almost_empty, i <= 2); end
        end
        write = 1'b0;
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_full got %b%b exp 10", full, empty); end
    endtask
    task automatic test_overflow();
        write = 1'b1;
        data_in = 8'hAA;
        cyc();
        write = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        cyc();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        read = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data got %h exp %h", data_out, 8'(i)); end
            checks++; if (almost_empty !== (16 - i <= 2)) begin errors++; $display("FAIL drain_ae at %0d got %b exp %b", i, almost_empty, 16 - i <= 2); end
        end
        read = 1'b0;
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 1/0", empty, count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_unf got %b exp 0", underflow); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask
    task automatic test_simul_full();
        fill(16, 8'h01);
        read = 1'b1;
        write = 1'b1;
        data_in = 8'h55;
        cyc();
        write = 1'b0;
        checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL simfull_state got %0d/%b exp 16/0", count, overflow); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL simfull_dout got %h exp 01", data_out); end
        for (int i = 1; i <= 16; i++) begin
            cyc();
            checks++; if (data_out !== ((i == 16) ? 8'h55 : 8'(i + 1))) begin errors++; $display("FAIL simfull_data got %h at read %0d", data_out, i); end
        end
        read = 1'b0;
        checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL simfull_end got %b/%b exp 1/0", empty, underflow); end
    endtask
    task automatic test_simul_empty();
        read = 1'b1;
        write = 1'b1;
        data_in = 8'h77;
        cyc();
        read = 1'b0;
        write = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simempty_unf got %b exp 1", underflow); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL simempty_count got %0d exp 1", count); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", underflow); end
        read = 1'b1;
        cyc();
        read = 1'b0;
        checks++; if (data_out !== 8'h77 || empty !== 1'b1) begin errors++; $display("FAIL simempty_data got %h/%b exp 77/1", data_out, empty); end
    endtask
    task automatic test_err_priority();
        read = 1'b1;
        err_clr = 1'b1;
        cyc();
        read = 1'b0;
        err_clr = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_prio got %b exp 1", underflow); end
        checks++; if (data_out !== 8'h77 || count !== 5'd0) begin errors++; $display("FAIL dropped_read got %h/%0d exp 77/0", data_out, count); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL err_prio_clr got %b exp 0", underflow); end
    endtask
    task automatic test_wrap();
        fill(3, 8'h80);
        read = 1'b1;
        write = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_in = 8'h83 + 8'(k);
            cyc();
            checks++; if (data_out !== 8'h80 + 8'(k)) begin errors++; $display("FAIL wrap_data got %h exp %h", data_out, 8'h80 + 8'(k)); end
            checks++; if ({count, full, empty, almost_full, almost_empty} !== {5'd3, 4'b0000}) begin errors++; $display("FAIL wrap_flags got %0d %b%b%b%b exp 3 0000", count, full, empty, almost_full, almost_empty); end
        end
        write = 1'b0;
        for (int k = 40; k < 43; k++) begin
            cyc();
            checks++; if (data_out !== 8'h80 + 8'(k)) begin errors++; $display("FAIL wrap_tail got %h exp %h", data_out, 8'h80 + 8'(k)); end
        end
        read = 1'b0;
        checks++; if (empty !== 1'b1 || {overflow, underflow} !== 2'b00) begin errors++; $display("FAIL wrap_end got %b/%b%b exp 1/00", empty, overflow, underflow); end
    endtask
    task automatic test_fwft();
        write2 = 1'b1;
        data_in2 = 8'h3C;
        cyc();
        write2 = 1'b0;
        checks++; if (data_out2 !== 8'h3C || empty2 !== 1'b0) begin errors++; $display("FAIL fwft_head got %h/%b exp 3c/0", data_out2, empty2); end
        cyc();
        checks++; if (data_out2 !== 8'h3C) begin errors++; $display("FAIL fwft_hold got %h exp 3c", data_out2); end
        read2 = 1'b1;
        cyc();
        read2 = 1'b0;
        checks++; if (empty2 !== 1'b1 || data_out2 !== 8'h00) begin errors++; $display("FAIL fwft_pop got %b/%h exp 1/00", empty2, data_out2); end
        write2 = 1'b1;
        data_in2 = 8'hD1;
        cyc();
        data_in2 = 8'hD2;
        cyc();
        write2 = 1'b0;
        read2 = 1'b1;
        cyc();
        read2 = 1'b0;
        checks++; if (data_out2 !== 8'hD2 || count2 !== 5'd1) begin errors++; $display("FAIL fwft_next got %h/%0d exp d2/1", data_out2, count2); end
    endtask
    task automatic test_reset_mid();
        fill(8, 8'h40);
        read = 1'b1;
        cyc();
        read = 1'b0;
        checks++; if (count !== 5'd7 || data_out !== 8'h40) begin errors++; $display("FAIL mid_pre got %0d/%h exp 7/40", count, data_out); end
        write = 1'b1;
        data_in = 8'hEE;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        write = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset got %0d/%b exp 0/1", count, empty); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", data_out); end
        checks++; if (data_out2 !== 8'h00 || empty2 !== 1'b1) begin errors++; $display("FAIL mid_fwft got %h/%b exp 00/1", data_out2, empty2); end
    endtask
    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow();
        test_simul_full();
        test_simul_empty();
        test_err_priority();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the successor to the fixed 8x8 synchronous FIFO, generalised in width, depth and read mode. It adds a programmable almost-full/almost-empty threshold pair, a live fill count, sticky overflow/underflow error flags, and read-while-full pass-through. It sits between any producer/consumer pair sharing `clk` and replaces fixed-size FIFO instances in the datapath.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of storage locations; power of two, ≥4.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ this value; 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ this value; 0..DEPTH-1.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `write`  in  1  write request.
- `data_in`  in  WIDTH  write data.
- `read`  in  1  read request.
- `err_clr`  in  1  clears `overflow` and `underflow`.
- `data_out`  out  WIDTH  read data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_THRESH.
- `almost_empty`  out  1  count ≤ AE_THRESH.
- `count`  out  $clog2(DEPTH)+1  current number of stored words.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read was dropped.

## Operation
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
- Read accept: `rd_ok = read && !empty`.
- Write accept: `wr_ok = write && (!full || rd_ok)`.
  - At full, a simultaneous accepted read frees a slot, so the write is also accepted.
  - At empty, a simultaneous write does not enable the read; the read is rejected.
- Count update:
  - `wr_ok` only: +1.
  - `rd_ok` only: −1.
  - Both or neither: unchanged.
- Accepted write stores `data_in` at the write pointer, then increments the write pointer.
- Accepted read increments the read pointer.
- Standard mode (FWFT=0):
  - On `rd_ok`, `data_out` registers the word at the read pointer.
  - Otherwise `data_out` holds its value.
- FWFT mode (FWFT=1):
  - `data_out` combinationally shows the word at the read pointer while !empty, and 0 while empty.
  - `rd_ok` pops that word.
- Flags: `full`, `empty`, `almost_full` and `almost_empty` decode combinationally from the registered `count`.
- Error flags:
  - `overflow` sets on `write && !wr_ok`.
  - `underflow` sets on `read && !rd_ok`.
  - Both clear on `err_clr`; a set event in the same cycle as `err_clr` wins.
  - Dropped operations leave pointers, count and memory unchanged.
- Reset clears pointers, `count`, `overflow`, `underflow` and the registered `data_out`. Memory contents are not cleared.

## Timing
- Reset values:
  - `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
  - `overflow`=0, `underflow`=0, `data_out`=0.
- Reset takes effect at the rising edge where it is sampled high. It overrides any `read`/`write` in the same cycle, including mid-burst; the FIFO is empty afterwards.
- Write-to-flag latency: 1 cycle; `count` and flags reflect a write after the edge that accepts it.
- Read latency:
  - FWFT=0: `data_out` valid 1 cycle after the accepting edge.
  - FWFT=1: the head word is visible the cycle after it is written into an empty FIFO; pop takes effect at the edge.
- Throughput: one read and one write per cycle, sustained indefinitely, including at full.
- Error flags assert the cycle after the offending request and persist until `err_clr` or `reset`.

## Test plan
- Reset and fill (DEPTH=16, AF_THRESH=14):
  - Assert `reset` for 1 cycle → all outputs at their reset values.
  - Write 0x01..0x10 on 16 consecutive cycles → `almost_full`=1 once count=14; after the 16th edge `full`=1, `count`=16.
- Overflow: with the FIFO full, `write`=1, `data_in`=0xAA, `read`=0 → `overflow`=1 next cycle, `count` stays 16.
  - Then drain 16 reads → data_out sequence 0x01..0x10 with no 0xAA; `empty`=1, `almost_empty`=1 at count ≤ 2; `underflow`=0.
- Simultaneous access:
  - At full, `read`=`write`=1 with `data_in`=0x55 → count stays 16, `overflow`=0; 0x55 emerges as the 16th subsequent read.
  - At empty, `read`=`write`=1 → `underflow`=1, count=1.
- Wrap-around: run 40 cycles of read+write at count=3 with an incrementing pattern → output order is preserved, no flag glitches, pointers wrap twice.
- FWFT=1: write 0x3C into an empty FIFO → `data_out`=0x3C the next cycle without `read`; one `read` → `empty`=1, `data_out`=0.
- Reset mid-burst:
  - Assert `reset` with `write`=1 at count=7 → count=0, `empty`=1 next cycle, `data_out`=0.
  - Set `underflow`, then assert `err_clr` → `underflow` clears the next cycle.
